// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD phase countdown timer.
// A phase duration is loaded as two BCD digits and counted down once per
// prescaler period. Every output is a register. tick marks each visible
// decrement. done marks expiry. load_error marks a rejected load.
module bcd_countdown_timer #(
   parameter int CLK_FREQ = 125_000_000,
   parameter int TICK_HZ  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   input  logic       enable,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       tick,
   output logic       done,
   output logic       running,
   output logic       load_error,
   output logic [1:0] state_dbg
);

   localparam int DIV = CLK_FREQ / TICK_HZ;
   localparam int P_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [P_W-1:0] P_MAX = P_W'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [P_W-1:0] p_q, p_d;
   logic [3:0]     tens_d, ones_d;
   logic           tick_d, done_d, err_d, running_d;

   logic [3:0]     dec_tens, dec_ones;
   logic           dec_zero;
   logic           load_valid, load_zero;
   logic           counting, term;

   // Handshake: load is a single-cycle request with no ready. It is always
   // accepted at the next clock edge, and it wins over a same-cycle
   // prescaler terminal count.
   assign load_valid = (load_tens <= 4'd9) && (load_ones <= 4'd9);
   assign load_zero  = (load_tens == 4'd0) && (load_ones == 4'd0);
   assign term       = (p_q == P_MAX);

   // The prescaler advances in RUN or PAUSE while enable is high. Counting
   // in the PAUSE->RUN edge keeps the paused time exactly equal to the
   // number of cycles enable was low.
   assign counting   = ((state_q == RUN) || (state_q == PAUSE)) && enable;

   // BCD decrement with borrow from tens. It saturates at 00.
   always_comb begin
      dec_tens = tens;
      dec_ones = ones;
      if (ones != 4'd0) begin
         dec_ones = ones - 4'd1;
      end else if (tens != 4'd0) begin
         dec_ones = 4'd9;
         dec_tens = tens - 4'd1;
      end
      dec_zero = (dec_tens == 4'd0) && (dec_ones == 4'd0);
   end

   // State register. It also holds the datapath and the registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         p_q        <= '0;
         tens       <= 4'd0;
         ones       <= 4'd0;
         tick       <= 1'b0;
         done       <= 1'b0;
         running    <= 1'b0;
         load_error <= 1'b0;
      end else begin
         state_q    <= state_d;
         p_q        <= p_d;
         tens       <= tens_d;
         ones       <= ones_d;
         tick       <= tick_d;
         done       <= done_d;
         running    <= running_d;
         load_error <= err_d;
      end
   end

   // Next state, prescaler and digits.
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      tens_d  = tens;
      ones_d  = ones;
      if (load) begin
         if (load_valid) begin
            tens_d = load_tens;
            ones_d = load_ones;
            p_d    = '0;
            if (load_zero) begin
               state_d = EXPIRED;
            end else if (enable) begin
               state_d = RUN;
            end else begin
               state_d = PAUSE;
            end
         end
      end else begin
         case (state_q)
            RUN, PAUSE: begin
               state_d = enable ? RUN : PAUSE;
               if (enable) begin
                  if (term) begin
                     p_d    = '0;
                     tens_d = dec_tens;
                     ones_d = dec_ones;
                     if (dec_zero) begin
                        state_d = EXPIRED;
                     end
                  end else begin
                     p_d = p_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // Output decode. These are the next values of the registered pulse and
   // status outputs.
   always_comb begin
      tick_d    = !load && counting && term;
      done_d    = (load && load_valid && load_zero) || (tick_d && dec_zero);
      err_d     = load && !load_valid;
      running_d = (state_d == RUN) || (state_d == PAUSE);
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Testbench for bcd_countdown_timer with CLK_FREQ=10 and TICK_HZ=1, so
// DIV=10. Expected pulse events (tick/done/load_error) are pushed into a
// queue when the stimulus is issued. A monitor pops and compares each
// event the DUT presents. Status outputs are checked directly.
module tb_bcd_countdown_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_tens = 4'd0;
   logic [3:0] load_ones = 4'd0;
   logic       enable = 1'b1;
   logic [3:0] tens, ones;
   logic       tick, done, running, load_error;
   logic [1:0] state_dbg;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         b;

   // Each entry is {cycle[15:0], tick, done, load_error, tens, ones}.
   logic [26:0] exp_q[$];

   bcd_countdown_timer #(.CLK_FREQ(10), .TICK_HZ(1)) dut (
      .clk(clk),
      .reset(reset),
      .load(load),
      .load_tens(load_tens),
      .load_ones(load_ones),
      .enable(enable),
      .tens(tens),
      .ones(ones),
      .tick(tick),
      .done(done),
      .running(running),
      .load_error(load_error),
      .state_dbg(state_dbg)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [26:0] ev(input int c, input logic t, input logic d,
                                      input logic e, input logic [7:0] dig);
      return {16'(c), t, d, e, dig};
   endfunction

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Call at a negedge. The load is sampled at the following posedge.
   task automatic drive_load(input logic [3:0] t, input logic [3:0] o, input logic en);
      load      = 1'b1;
      load_tens = t;
      load_ones = o;
      enable    = en;
      @(negedge clk);
      load      = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      fork
         // Monitor: every pulse the DUT shows must match the head of the queue.
         begin
            logic [26:0] obs, e;
            forever begin
               @(negedge clk);
               if (!reset && (tick || done || load_error)) begin
                  obs = {16'(cyc), tick, done, load_error, tens, ones};
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL pulse_unexpected: got cyc=%0d t/d/e=%b%b%b digits=%h, none expected",
                              cyc, tick, done, load_error, {tens, ones});
                  end else begin
                     e = exp_q.pop_front();
                     if (obs !== e) begin
                        errors++;
                        $display("FAIL pulse_event: got cyc=%0d t/d/e=%b digits=%h, expected cyc=%0d t/d/e=%b digits=%h",
                                 obs[26:11], obs[10:8], obs[7:0], e[26:11], e[10:8], e[7:0]);
                     end
                  end
               end
            end
         end
         // Stimulus
         begin
            // 1. Reset state, then idle with no pulses.
            @(negedge clk);
            check8("reset_digits", {tens, ones}, 8'h00);
            check1("reset_running", running, 1'b0);
            check1("reset_tick", tick, 1'b0);
            check1("reset_done", done, 1'b0);
            check1("reset_err", load_error, 1'b0);
            @(negedge clk);
            reset = 1'b0;
            wait_until(cyc + 50);
            check8("idle_digits", {tens, ones}, 8'h00);
            check8("idle_state", {6'd0, state_dbg}, 8'd0);

            // 2. Load 12 and check the borrow 10 -> 09.
            b = cyc + 1;
            exp_q.push_back(ev(b + 10, 1'b1, 1'b0, 1'b0, 8'h11));
            exp_q.push_back(ev(b + 20, 1'b1, 1'b0, 1'b0, 8'h10));
            exp_q.push_back(ev(b + 30, 1'b1, 1'b0, 1'b0, 8'h09));
            drive_load(4'd1, 4'd2, 1'b1);
            check1("load12_running", running, 1'b1);
            check8("load12_digits", {tens, ones}, 8'h12);
            wait_until(b + 30);

            // 3. Load 03 and run it to expiry.
            b = cyc + 1;
            exp_q.push_back(ev(b + 10, 1'b1, 1'b0, 1'b0, 8'h02));
            exp_q.push_back(ev(b + 20, 1'b1, 1'b0, 1'b0, 8'h01));
            exp_q.push_back(ev(b + 30, 1'b1, 1'b1, 1'b0, 8'h00));
            drive_load(4'd0, 4'd3, 1'b1);
            wait_until(b + 30);
            check1("expire_running", running, 1'b0);
            @(negedge clk);
            check1("expire_done_one_cycle", done, 1'b0);
            check1("expire_tick_one_cycle", tick, 1'b0);
            wait_until(cyc + 50);
            check8("expired_digits", {tens, ones}, 8'h00);
            check8("expired_state", {6'd0, state_dbg}, 8'd3);

            // 4. Load 02, pause for 25 cycles after the first tick.
            b = cyc + 1;
            exp_q.push_back(ev(b + 10, 1'b1, 1'b0, 1'b0, 8'h01));
            exp_q.push_back(ev(b + 45, 1'b1, 1'b1, 1'b0, 8'h00));
            drive_load(4'd0, 4'd2, 1'b1);
            wait_until(b + 10);
            enable = 1'b0;
            wait_until(b + 20);
            check8("pause_digits", {tens, ones}, 8'h01);
            check1("pause_running", running, 1'b1);
            check8("pause_state", {6'd0, state_dbg}, 8'd2);
            wait_until(b + 35);
            check8("pause_digits_late", {tens, ones}, 8'h01);
            enable = 1'b1;
            wait_until(b + 46);
            check8("pause_expired_state", {6'd0, state_dbg}, 8'd3);

            // 5a. Invalid loads while paused at 42 leave everything unchanged.
            drive_load(4'd4, 4'd2, 1'b0);
            check8("paused42_state", {6'd0, state_dbg}, 8'd2);
            b = cyc + 1;
            exp_q.push_back(ev(b, 1'b0, 1'b0, 1'b1, 8'h42));
            drive_load(4'hA, 4'd1, 1'b0);
            @(negedge clk);
            check1("err_one_cycle", load_error, 1'b0);
            check8("err_digits_kept", {tens, ones}, 8'h42);
            check8("err_state_kept", {6'd0, state_dbg}, 8'd2);
            b = cyc + 1;
            exp_q.push_back(ev(b, 1'b0, 1'b0, 1'b1, 8'h42));
            drive_load(4'd3, 4'hF, 1'b0);
            @(negedge clk);
            check8("err2_digits_kept", {tens, ones}, 8'h42);

            // 5b. Load 00 expires at once, with done and no tick.
            b = cyc + 1;
            exp_q.push_back(ev(b, 1'b0, 1'b1, 1'b0, 8'h00));
            drive_load(4'd0, 4'd0, 1'b1);
            check8("load00_state", {6'd0, state_dbg}, 8'd3);
            check1("load00_running", running, 1'b0);
            @(negedge clk);
            check1("load00_done_one_cycle", done, 1'b0);

            // 5c. Load 05 at the terminal count of 07: no decrement, no tick.
            b = cyc + 1;
            drive_load(4'd0, 4'd7, 1'b1);
            wait_until(b + 9);
            b = b + 10;
            exp_q.push_back(ev(b + 10, 1'b1, 1'b0, 1'b0, 8'h04));
            drive_load(4'd0, 4'd5, 1'b1);
            check8("preempt_digits", {tens, ones}, 8'h05);
            check1("preempt_tick", tick, 1'b0);
            wait_until(b + 10);

            // 6. Asynchronous reset mid-count from 15.
            b = cyc + 1;
            exp_q.push_back(ev(b + 10, 1'b1, 1'b0, 1'b0, 8'h14));
            drive_load(4'd1, 4'd5, 1'b1);
            wait_until(b + 15);
            #2 reset = 1'b1;
            #1;
            check8("async_reset_digits", {tens, ones}, 8'h00);
            check1("async_reset_running", running, 1'b0);
            check1("async_reset_done", done, 1'b0);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            wait_until(cyc + 30);
            check8("post_reset_digits", {tens, ones}, 8'h00);
            check8("post_reset_state", {6'd0, state_dbg}, 8'd0);
         end
      join_any
      disable fork;

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pulse_missing: got %0d expected events left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
